// File: rtl/blob_binarize_filter_if.sv
// Pixel-in / filtered-bit-out bundle for blob_binarize_filter.
// slave: the filter (takes i_* pixels, drives o_* bits); master: the source/sink.
interface blob_binarize_filter_if;
  logic        i_start;
  logic        i_pix_valid;
  logic [11:0] i_red;
  logic [11:0] i_green;
  logic [11:0] i_blue;
  logic        o_seq;
  logic        o_data_valid;
  logic        o_busy;
  logic        o_frame_done;

  modport master (
    output i_start, i_pix_valid, i_red, i_green, i_blue,
    input  o_seq, o_data_valid, o_busy, o_frame_done
  );

  modport slave (
    input  i_start, i_pix_valid, i_red, i_green, i_blue,
    output o_seq, o_data_valid, o_busy, o_frame_done
  );
endinterface

// File: rtl/blob_binarize_filter.sv
// RGB -> 1-bit foreground, 3x3 majority denoise, one bit per pixel in raster order.
// Ports: i_clk, i_rst_n (sync, active-low), bus (pixels in, o_seq/o_data_valid/o_busy/o_frame_done out).
module blob_binarize_filter #(
  parameter int          IMG_COL = 800,
  parameter int          IMG_ROW = 600,
  parameter logic [11:0] THRESH  = 12'd2048,
  parameter bit          INVERT  = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  blob_binarize_filter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int          CW       = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam logic [9:0]  COL_LAST = 10'(IMG_COL - 1);
  localparam logic [9:0]  ROW_LAST = 10'(IMG_ROW - 1);
  localparam logic [18:0] TOTAL    = 19'(IMG_COL * IMG_ROW);

  state_t state;
  state_t state_nx;

  logic [9:0]         in_col;
  logic [9:0]         in_row;
  logic [18:0]        out_cnt;
  logic [IMG_COL-1:0] lb_mid;
  logic [IMG_COL-1:0] lb_top;
  logic [2:0]         win_c1;
  logic [2:0]         win_c2;

  logic seq_q;
  logic dv_q;
  logic busy_q;
  logic done_q;

  logic          clear;
  logic          accept;
  logic          flush_emit;
  logic          run_emit;
  logic          emit;
  logic          border;
  logic          seq_nx;
  logic [13:0]   lum_sum;
  logic [11:0]   lum;
  logic          bin;
  logic [CW-1:0] idx;
  logic [2:0]    col_new;

  function automatic logic majority(input logic [8:0] w);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n >= 4'd5;
  endfunction

  always_comb begin
    lum_sum = {2'b00, bus.i_red}
            + {1'b0, bus.i_green, 1'b0}
            + {2'b00, bus.i_blue};
    lum     = lum_sum[13:2];
    bin     = (lum >= THRESH) ^ INVERT;
  end

  assign idx = in_col[CW-1:0];

  // Column entering the window: rows r-2, r-1, r at column c.
  assign col_new = {lb_top[idx], lb_mid[idx], bin};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clear      = 1'b0;
    accept     = 1'b0;
    flush_emit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          state_nx = S_RUN;
          clear    = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.i_pix_valid) begin
          accept = 1'b1;
          if (in_row == ROW_LAST && in_col == COL_LAST) begin
            state_nx = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        flush_emit = 1'b1;
        if (out_cnt == TOTAL - 19'd1) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Window centre is (in_row-1, in_col-1); it exists once IMG_COL+1
  // pixels are in. Columns 0/1 wrap or hit the left/right edge, row 1
  // puts the centre on row 0: all forced to 0.
  always_comb begin
    run_emit = accept
             && ((in_row >= 10'd2)
             || (in_row == 10'd1 && in_col != 10'd0));
    border   = (in_col < 10'd2) || (in_row < 10'd2);
    emit     = run_emit | flush_emit;
    seq_nx   = run_emit && !border
             && majority({win_c2, win_c1, col_new});
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clear) begin
      in_col  <= '0;
      in_row  <= '0;
      out_cnt <= '0;
      lb_mid  <= '0;
      lb_top  <= '0;
      win_c1  <= '0;
      win_c2  <= '0;
    end else begin
      if (accept) begin
        lb_top[idx] <= lb_mid[idx];
        lb_mid[idx] <= bin;
        win_c2      <= win_c1;
        win_c1      <= col_new;
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= in_row + 10'd1;
        end else begin
          in_col <= in_col + 10'd1;
        end
      end
      if (emit) begin
        out_cnt <= out_cnt + 19'd1;
      end
    end
  end

  // busy stays up through the frame_done cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      seq_q  <= 1'b0;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      seq_q  <= seq_nx;
      dv_q   <= emit;
      busy_q <= (state_nx != S_IDLE) || (state == S_DONE);
      done_q <= (state == S_DONE);
    end
  end

  assign bus.o_seq        = seq_q;
  assign bus.o_data_valid = dv_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_blob_binarize_filter.sv
// Self-checking bench for blob_binarize_filter on a reduced 16x12 frame.
// Two DUTs (INVERT=0/1) share stimulus; outputs are checked against an image-level model.
module tb_blob_binarize_filter;

  localparam int COL      = 16;
  localparam int ROW      = 12;
  localparam int N        = COL * ROW;
  localparam int INTERIOR = (COL - 2) * (ROW - 2);
  localparam int LIMIT    = 8 * N + 200;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  blob_binarize_filter_if bus0 ();
  blob_binarize_filter_if bus1 ();

  blob_binarize_filter #(
    .IMG_COL(COL), .IMG_ROW(ROW),
    .THRESH(12'd2048), .INVERT(1'b0)
  ) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus0.slave)
  );

  blob_binarize_filter #(
    .IMG_COL(COL), .IMG_ROW(ROW),
    .THRESH(12'd2048), .INVERT(1'b1)
  ) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus1.slave)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  int red [ROW][COL];
  int grn [ROW][COL];
  int blu [ROW][COL];

  bit   cap0[$];
  bit   cap1[$];
  int   done_cnt0;
  int   done_cnt1;
  int   first_t;
  int   last_t;
  int   done_t;
  bit   have_first;
  logic busy_done;
  logic busy_after;

  always @(negedge i_clk) begin
    if (bus0.o_data_valid) begin
      cap0.push_back(bus0.o_seq);
      if (!have_first) begin
        first_t    = cyc;
        have_first = 1'b1;
      end
      last_t = cyc;
    end
    if (bus1.o_data_valid) cap1.push_back(bus1.o_seq);
    if (bus0.o_frame_done) begin
      done_cnt0++;
      done_t    = cyc;
      busy_done = bus0.o_busy;
    end
    if (bus1.o_frame_done) done_cnt1++;
    if (done_cnt0 > 0 && cyc == done_t + 1) busy_after = bus0.o_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: binarize by luminance, then majority of the 3x3
  // neighbourhood for interior pixels, 0 on the image border.
  function automatic bit fg(int r, int c, bit inv);
    int y;
    y = (red[r][c] + 2 * grn[r][c] + blu[r][c]) / 4;
    return (y >= 2048) ^ inv;
  endfunction

  function automatic bit ref_out(int r, int c, bit inv);
    int n;
    n = 0;
    if (r == 0 || r == ROW - 1 || c == 0 || c == COL - 1) return 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        n += int'(fg(r + dr, c + dc, inv));
    return n >= 5;
  endfunction

  task automatic fill_const(input int v);
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        red[r][c] = v;
        grn[r][c] = v;
        blu[r][c] = v;
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        red[r][c] = $urandom_range(0, 4095);
        grn[r][c] = $urandom_range(0, 4095);
        blu[r][c] = $urandom_range(0, 4095);
      end
  endtask

  task automatic set_px(input int r, input int c, input int v);
    red[r][c] = v;
    grn[r][c] = v;
    blu[r][c] = v;
  endtask

  task automatic drive(input bit st, input bit v,
                       input int r, input int g, input int b);
    bus0.i_start     = st;
    bus1.i_start     = st;
    bus0.i_pix_valid = v;
    bus1.i_pix_valid = v;
    bus0.i_red       = 12'(r);
    bus1.i_red       = 12'(r);
    bus0.i_green     = 12'(g);
    bus1.i_green     = 12'(g);
    bus0.i_blue      = 12'(b);
    bus1.i_blue      = 12'(b);
  endtask

  task automatic drive_junk(input bit v);
    drive(1'b0, v, $urandom_range(0, 4095),
          $urandom_range(0, 4095), $urandom_range(0, 4095));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {24'd0,
              bus0.o_seq, bus0.o_data_valid, bus0.o_busy, bus0.o_frame_done,
              bus1.o_seq, bus1.o_data_valid, bus1.o_busy, bus1.o_frame_done},
        32'd0);
  endtask

  task automatic run_frame(input string tag, input bit stall, input bit poke,
                           input int ones0, input int ones1);
    int k, guard, t0, mm0, mm1, o0, o1, r, c;
    bit v, e0, e1;
    cap0.delete();
    cap1.delete();
    done_cnt0  = 0;
    done_cnt1  = 0;
    have_first = 1'b0;
    busy_done  = 1'bx;
    busy_after = 1'bx;
    for (int i = 0; i < 3; i++) begin
      drive_junk(1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    t0 = cyc;
    chk({tag, " busy_rise"}, {31'd0, bus0.o_busy}, 32'd1);
    k = 0;
    while (k < N) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        r = k / COL;
        c = k % COL;
        drive(poke && k == N / 2, 1'b1, red[r][c], grn[r][c], blu[r][c]);
      end else begin
        drive_junk(1'b0);
        bus0.i_start = poke && k == N / 2;
        bus1.i_start = poke && k == N / 2;
      end
      tick();
      if (v) k++;
    end
    guard = 0;
    while ((done_cnt0 == 0 || done_cnt1 == 0) && guard < LIMIT) begin
      drive_junk(1'b1);
      tick();
      guard++;
    end
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk({tag, " timeout"}, {31'd0, guard < LIMIT}, 32'd1);
    chk({tag, " beats0"}, cap0.size(), N);
    chk({tag, " beats1"}, cap1.size(), N);
    mm0 = 0;
    mm1 = 0;
    o0  = 0;
    o1  = 0;
    for (int i = 0; i < N; i++) begin
      e0 = ref_out(i / COL, i % COL, 1'b0);
      e1 = ref_out(i / COL, i % COL, 1'b1);
      if (i >= cap0.size() || cap0[i] != e0) mm0++;
      if (i >= cap1.size() || cap1[i] != e1) mm1++;
      if (i < cap0.size()) o0 += int'(cap0[i]);
      if (i < cap1.size()) o1 += int'(cap1[i]);
    end
    chk({tag, " seq0_mismatches"}, mm0, 0);
    chk({tag, " seq1_mismatches"}, mm1, 0);
    if (ones0 >= 0) chk({tag, " ones0"}, o0, ones0);
    if (ones1 >= 0) chk({tag, " ones1"}, o1, ones1);
    chk({tag, " done_pulses0"}, done_cnt0, 1);
    chk({tag, " done_pulses1"}, done_cnt1, 1);
    chk({tag, " done_after_last"}, done_t, last_t + 1);
    chk({tag, " busy_at_done"}, {31'd0, busy_done}, 32'd1);
    chk({tag, " busy_after_done"}, {31'd0, busy_after}, 32'd0);
    if (!stall) begin
      chk({tag, " first_latency"}, first_t - t0, COL + 2);
      chk({tag, " contiguous"}, last_t - first_t, N - 1);
    end
  endtask

  task automatic reset_mid_frame();
    int r, c;
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    for (int k = 0; k < N / 2; k++) begin
      r = k / COL;
      c = k % COL;
      drive(1'b0, 1'b1, red[r][c], grn[r][c], blu[r][c]);
      tick();
    end
    drive(1'b0, 1'b0, 0, 0, 0);
    i_rst_n = 1'b0;
    tick();
    chk_all_zero("midframe_reset_outputs");
    i_rst_n = 1'b1;
    tick();
    chk_all_zero("after_reset_idle");
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0);
    i_rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    i_rst_n = 1'b1;
    tick();

    fill_const(4095);
    run_frame("white", 1'b0, 1'b0, INTERIOR, 0);

    fill_const(0);
    set_px(5, 5, 4095);
    run_frame("single_pixel", 1'b0, 1'b0, 0, INTERIOR);

    fill_const(0);
    for (int r = 4; r <= 6; r++)
      for (int c = 6; c <= 8; c++)
        set_px(r, c, 4095);
    run_frame("block3x3", 1'b0, 1'b0, 5, INTERIOR - 5);
    run_frame("block3x3_stall", 1'b1, 1'b0, 5, INTERIOR - 5);

    fill_const(2048);
    run_frame("thresh_2048", 1'b0, 1'b0, INTERIOR, 0);

    fill_const(2047);
    run_frame("thresh_2047", 1'b0, 1'b0, 0, INTERIOR);

    fill_rand();
    run_frame("random", 1'b0, 1'b0, -1, -1);
    fill_rand();
    run_frame("random_stall", 1'b1, 1'b1, -1, -1);

    fill_const(4095);
    reset_mid_frame();
    run_frame("white_after_reset", 1'b0, 1'b1, INTERIOR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blob_binarize_filter.md
# blob_binarize_filter

Front-end stage of the blob-counting path. Converts the camera's RGB pixel stream into a 1-bit foreground stream, removes salt-and-pepper noise with a 3x3 majority filter, and drives the blob labeller's `i_seq` / `i_data_valid` inputs. It emits exactly one filtered bit per image pixel in raster order, so the labeller's end-of-frame pixel count stays valid.

## Interface
- `IMG_COL`, 800, pixels per row.
- `IMG_ROW`, 600, rows per frame.
- `THRESH`, 12'd2048, luminance threshold; foreground when luminance >= `THRESH`.
- `INVERT`, 0, when 1 the binarized bit is inverted before filtering (dark objects).
- `i_clk` in 1, single clock; all logic on its rising edge.
- `i_rst_n` in 1, reset, synchronous and active-low.
- `i_start` in 1, one-cycle frame start request; honoured only in S_IDLE.
- `i_pix_valid` in 1, an input pixel is present this cycle.
- `i_red`, `i_green`, `i_blue` in 12 each, pixel colour.
- `o_seq` out 1, filtered foreground bit; goes to the labeller's `i_seq`.
- `o_data_valid` out 1, `o_seq` is valid this cycle.
- `o_busy` out 1, high from S_RUN entry until S_DONE exit.
- `o_frame_done` out 1, one-cycle pulse after the last output bit.

## Operation
- Luminance: y = (R + 2*G + B) >> 2.
  - Sum is 14-bit; the result is truncated to 12 bits with no overflow.
  - bin = (y >= `THRESH`) XOR `INVERT`.
- Storage:
  - Two 1-bit line buffers of `IMG_COL` entries each.
  - A 3x3 window of shift registers.
  - Input counters `in_col` and `in_row` (10 bits each) and a 19-bit output counter `out_cnt`.
- Filter output for centre (r,c) = 1 when at least 5 of the 9 window bits are 1.
- Border rule: the output is forced to 0 when r==0, r==`IMG_ROW`-1, c==0 or c==`IMG_COL`-1. Window contents wrapping across a row edge are therefore never used.
- FSM states: S_IDLE, S_RUN, S_FLUSH, S_DONE.
  - S_IDLE -> S_RUN on `i_start`. On entry, clear counters, line buffers and window.
  - S_RUN: a pixel is accepted when `i_pix_valid` is high. `in_col` wraps at `IMG_COL`-1 and increments `in_row`.
  - S_RUN -> S_FLUSH on acceptance of pixel (`IMG_ROW`-1, `IMG_COL`-1).
  - S_FLUSH: emits one output per cycle, ignoring `i_pix_valid`, until `out_cnt` == `IMG_COL`*`IMG_ROW`. All flush outputs are border or last-row positions and so are 0.
  - S_FLUSH -> S_DONE when the last output is emitted.
  - S_DONE: pulse `o_frame_done` for one cycle, then return to S_IDLE.
- Output for raster index k is produced when input index k+`IMG_COL`+1 is accepted. The first `IMG_COL`+1 accepted pixels produce no output.
- `i_start` outside S_IDLE is ignored.
- `i_pix_valid` in S_IDLE, S_FLUSH or S_DONE is ignored; the data is dropped.
- Reset at any point, including mid-frame:
  - State returns to S_IDLE.
  - All outputs are 0; line buffers, window and counters are cleared.
  - The next frame starts clean.

## Timing
- Reset values: `o_seq`=0, `o_data_valid`=0, `o_busy`=0, `o_frame_done`=0.
- Outputs are registered.
  - `o_data_valid` is high the cycle after the accepting edge of input index k+`IMG_COL`+1.
  - In S_FLUSH it is high on consecutive cycles.
- `o_busy` rises the cycle after `i_start` is sampled in S_IDLE.
- `o_data_valid` is high for exactly `IMG_COL`*`IMG_ROW` cycles per frame, never more than once per cycle.
- Input gaps (`i_pix_valid` low) produce matching output gaps; the content of the output stream does not depend on stall pattern.
- `o_frame_done` is asserted the cycle after the final `o_data_valid`. `o_busy` falls in the same cycle as `o_frame_done` deasserts.
- Flush lasts `IMG_COL`+1 cycles. Minimum frame time is `IMG_COL`*`IMG_ROW`+`IMG_COL`+3 cycles after `i_start`.

## Test plan
- All pixels R=G=B=4095, continuous valid -> 480000 `o_data_valid` beats; 477204 ones (798x598 interior), all border outputs 0; one `o_frame_done` pulse.
- Black frame with a single white pixel at (100,100) -> all 480000 outputs are 0 (noise removed).
- Black frame with a white 3x3 block at rows 49-51, cols 59-61 -> exactly 5 ones, at (49,60), (50,59), (50,60), (50,61), (51,60); the block corners give 0.
- Threshold boundary: R=G=B=2048 gives interior ones; R=G=B=2047 gives all zeros. With `INVERT`=1 these results swap.
- Same image as the 3x3-block case with `i_pix_valid` toggled pseudo-randomly (about 50% duty) -> bit-identical output sequence; total valid beats = 480000.
- Assert `i_rst_n` low for one cycle at pixel 200000, then send `i_start` and a full white frame -> the outputs match the first scenario exactly. `i_start` pulsed mid-frame has no effect.
